// File: rtl/wb_ram_slave_b3.sv
// Wishbone B3 byte-laned RAM slave with registered-feedback incrementing bursts.
// Out-of-range beats within the 256 MiB window terminate with err_o.
//
// state   | meaning
// IDLE    | no termination driven, waiting for cyc_i & stb_i
// CLASSIC | one-shot ack/err pending for the presented beat
// BURST   | ack held every beat, next word prefetched from predicted address
module wb_ram_slave_b3 #(
  parameter int data_width = 32,
  parameter int addr_width = 13,
  parameter int mem_words  = 2048
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] adr_i,
  input  logic [31:0] dat_i,
  output logic [31:0] dat_o,
  input  logic [3:0]  sel_i,
  input  logic        we_i,
  input  logic        cyc_i,
  input  logic        stb_i,
  input  logic [2:0]  cti_i,
  input  logic [1:0]  bte_i,
  output logic        ack_o,
  output logic        err_o
);

  localparam int idx_w = addr_width - 2;
  localparam int off_w = 26;

  typedef enum logic [1:0] {IDLE, CLASSIC, BURST} state_t;

  state_t           state, state_n;
  logic [off_w-1:0] cur_w, cur_n, req_w, nxt_w, rd_w;
  logic             ack_q, err_q, ack_n, err_n;
  logic             rd_en, zero_dat;
  logic             req, term_ok;
  logic [31:0]      mem [mem_words];
  logic [idx_w-1:0] wr_idx;
  logic             unused_bits;

  function automatic logic [off_w-1:0] next_word(input logic [off_w-1:0] w,
                                                 input logic [1:0] bte);
    case (bte)
      2'b01:   next_word = {w[off_w-1:2], w[1:0] + 2'd1};
      2'b10:   next_word = {w[off_w-1:3], w[2:0] + 3'd1};
      2'b11:   next_word = {w[off_w-1:4], w[3:0] + 4'd1};
      default: next_word = w + 26'd1;
    endcase
  endfunction

  // Range check spans the whole window offset so aliases above the RAM error
  // instead of silently wrapping onto low words.
  function automatic logic in_range(input logic [off_w-1:0] w);
    in_range = (w < 26'(mem_words));
  endfunction

  assign req     = cyc_i & stb_i;
  assign req_w   = adr_i[27:2];
  assign nxt_w   = next_word(cur_w, bte_i);
  assign term_ok = req & (req_w == cur_w);
  assign ack_o   = ack_q & term_ok;
  assign err_o   = err_q & term_ok;
  assign wr_idx  = adr_i[addr_width-1:2];

  assign unused_bits = ^{adr_i[31:28], adr_i[1:0], rd_w[off_w-1:idx_w]};

  always_comb begin
    state_n  = state;
    cur_n    = cur_w;
    ack_n    = 1'b0;
    err_n    = 1'b0;
    rd_en    = 1'b0;
    zero_dat = 1'b0;
    rd_w     = req_w;
    case (state)
      IDLE: begin
        if (req) begin
          cur_n = req_w;
          if (!in_range(req_w)) begin
            err_n    = 1'b1;
            zero_dat = 1'b1;
            state_n  = CLASSIC;
          end else begin
            ack_n   = 1'b1;
            rd_en   = 1'b1;
            state_n = (cti_i == 3'b010) ? BURST : CLASSIC;
          end
        end
      end
      CLASSIC: state_n = IDLE;
      BURST: begin
        // Only a matching, continuing beat keeps the pipeline; anything else drops to IDLE.
        if (term_ok && cti_i == 3'b010) begin
          cur_n = nxt_w;
          rd_w  = nxt_w;
          if (!in_range(nxt_w)) begin
            err_n    = 1'b1;
            zero_dat = 1'b1;
            state_n  = CLASSIC;
          end else begin
            ack_n = 1'b1;
            rd_en = 1'b1;
          end
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      cur_w <= '0;
      ack_q <= 1'b0;
      err_q <= 1'b0;
      dat_o <= '0;
    end else begin
      state <= state_n;
      cur_w <= cur_n;
      ack_q <= ack_n;
      err_q <= err_n;
      if (zero_dat)
        dat_o <= '0;
      else if (rd_en)
        dat_o <= mem[rd_w[idx_w-1:0]];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && ack_o && we_i) begin
      for (int b = 0; b < 4; b++)
        if (sel_i[b]) mem[wr_idx][8*b +: 8] <= dat_i[8*b +: 8];
    end
  end

endmodule

// File: tb/tb_wb_ram_slave_b3.sv
// Scoreboard bench for wb_ram_slave_b3: driver pushes expected terminations,
// a negedge monitor pops and compares against a word-array reference model.
module tb_wb_ram_slave_b3;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] adr_i, dat_i, dat_o;
  logic [3:0]  sel_i;
  logic        we_i, cyc_i, stb_i;
  logic [2:0]  cti_i;
  logic [1:0]  bte_i;
  logic        ack_o, err_o;

  always #5 clk_i = ~clk_i;

  wb_ram_slave_b3 dut (
    .clk_i(clk_i), .rst_i(rst_i), .adr_i(adr_i), .dat_i(dat_i), .dat_o(dat_o),
    .sel_i(sel_i), .we_i(we_i), .cyc_i(cyc_i), .stb_i(stb_i), .cti_i(cti_i),
    .bte_i(bte_i), .ack_o(ack_o), .err_o(err_o)
  );

  typedef struct {
    bit          is_err;
    bit          chk;
    logic [31:0] dat;
  } exp_t;

  exp_t        expq[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] model [2048];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  function automatic int unsigned widx(input logic [31:0] a);
    return (a - 32'h1000_0000) >> 2;
  endfunction

  function automatic bit oor(input logic [31:0] a);
    return widx(a) >= 2048;
  endfunction

  function automatic logic [31:0] next_adr(input logic [31:0] a, input logic [1:0] bte);
    int unsigned bytes, base;
    if (bte == 2'b00) return a + 32'd4;
    bytes = 8 << bte;
    base  = a - (a % bytes);
    return base + ((a - base + 4) % bytes);
  endfunction

  always @(negedge clk_i) begin
    if (!rst_i && (ack_o || err_o)) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_term: ack=%b err=%b with nothing pending", ack_o, err_o);
      end else begin
        mon_e = expq.pop_front();
        check("term_err", 32'(err_o), 32'(mon_e.is_err));
        check("term_ack", 32'(ack_o), 32'(mon_e.is_err ? 1'b0 : 1'b1));
        if (mon_e.chk) check("rd_data", dat_o, mon_e.dat);
      end
    end
  end

  task automatic release_bus();
    cyc_i = 1'b0;
    stb_i = 1'b0;
    we_i  = 1'b0;
    cti_i = 3'b000;
  endtask

  // abort_mode: 1 = drop cyc after beat abort_at, 2 = reset during the next beat
  task automatic xfer(input logic [31:0] a0, input int n, input bit burst, input bit we,
                      input logic [1:0] bte, input logic [3:0] sel, input bit fixd,
                      input logic [31:0] wbase, input int stall_at, input int mism_at,
                      input int abort_at, input int abort_mode);
    logic [31:0] a, wd;
    int          w, waits, exp_w;
    bit          got, was_err;
    a = a0;
    exp_w = 1;
    was_err = 1'b0;
    for (int i = 0; i < n; i++) begin
      wd    = fixd ? wbase * (i + 1) : $urandom;
      cyc_i = 1'b1;
      stb_i = 1'b1;
      adr_i = a;
      we_i  = we;
      dat_i = wd;
      sel_i = sel;
      bte_i = bte;
      cti_i = !burst ? 3'b000 : ((i == n - 1) ? 3'b111 : 3'b010);
      if (i == mism_at) begin
        adr_i = a ^ 32'h40;
        @(negedge clk_i);
        check("mismatch_noterm", 32'({ack_o, err_o}), 32'd0);
        @(posedge clk_i); #1;
        adr_i = a;
        exp_w = 1;
      end
      w = widx(a);
      if (oor(a)) expq.push_back('{is_err: 1'b1, chk: 1'b1, dat: 32'h0});
      else if (we) begin
        for (int b = 0; b < 4; b++) if (sel[b]) model[w][8*b +: 8] = wd[8*b +: 8];
        expq.push_back('{is_err: 1'b0, chk: 1'b0, dat: 32'h0});
      end else expq.push_back('{is_err: 1'b0, chk: 1'b1, dat: model[w]});
      waits = 0;
      got   = 1'b0;
      while (!got && waits <= 12) begin
        @(negedge clk_i);
        if (ack_o || err_o) begin
          got     = 1'b1;
          was_err = err_o;
        end else begin
          waits++;
          @(posedge clk_i); #1;
        end
      end
      if (!got) begin
        checks++;
        errors++;
        $display("FAIL timeout: no termination for adr %h after %0d cycles, want one", a, waits);
        void'(expq.pop_back());
        release_bus();
        @(posedge clk_i); #1;
        return;
      end
      check("latency", 32'(waits), 32'(exp_w));
      @(posedge clk_i); #1;
      if (was_err) break;
      exp_w = burst ? 1'b0 : 1'b1;
      if (i == stall_at) begin
        stb_i = 1'b0;
        repeat (2) begin
          @(negedge clk_i);
          check("stall_noterm", 32'({ack_o, err_o}), 32'd0);
          @(posedge clk_i); #1;
        end
        exp_w = 1;
      end
      if (i == abort_at && abort_mode == 1) begin
        release_bus();
        repeat (2) begin
          @(negedge clk_i);
          check("cyc_drop_noterm", 32'({ack_o, err_o}), 32'd0);
          @(posedge clk_i); #1;
        end
        return;
      end
      if (i == abort_at && abort_mode == 2) begin
        adr_i = next_adr(a, bte);
        dat_i = $urandom;
        cti_i = 3'b010;
        stb_i = 1'b1;
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        check("rst_abort_term", 32'({ack_o, err_o}), 32'd0);
        check("rst_abort_dat", dat_o, 32'd0);
        release_bus();
        @(posedge clk_i); #1;
        return;
      end
      if (burst) a = next_adr(a, bte);
    end
    @(negedge clk_i);
    check("post_term_idle", 32'({ack_o, err_o}), 32'd0);
    release_bus();
    @(posedge clk_i); #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          rb;
    int          rn, st, mm;
    logic [31:0] ra;
    rst_i = 1'b1;
    adr_i = '0;
    dat_i = '0;
    sel_i = '0;
    bte_i = '0;
    release_bus();
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    check("reset_ack", 32'(ack_o), 32'd0);
    check("reset_err", 32'(err_o), 32'd0);
    check("reset_dat", dat_o, 32'd0);
    @(posedge clk_i); #1;

    for (int k = 0; k < 128; k++)
      xfer(32'h1000_0000 + k * 64, 16, 1, 1, 2'b00, 4'hF, 0, 0, -1, -1, -1, 0);

    xfer(32'h1000_0010, 1, 0, 1, 2'b00, 4'hF, 1, 32'hDEAD_BEEF, -1, -1, -1, 0);
    xfer(32'h1000_0010, 1, 0, 0, 2'b00, 4'hF, 0, 0, -1, -1, -1, 0);
    xfer(32'h1000_0010, 1, 0, 1, 2'b00, 4'h1, 1, 32'h0000_00AA, -1, -1, -1, 0);
    xfer(32'h1000_0010, 1, 0, 0, 2'b00, 4'hF, 0, 0, -1, -1, -1, 0);
    check("dat_hold_lane", dat_o, 32'hDEAD_BEAA);
    xfer(32'h1000_0010, 1, 0, 1, 2'b00, 4'h0, 1, 32'h1234_5678, -1, -1, -1, 0);
    xfer(32'h1000_0010, 1, 0, 0, 2'b00, 4'hF, 0, 0, -1, -1, -1, 0);

    xfer(32'h1000_0100, 4, 1, 1, 2'b00, 4'hF, 1, 32'h11, -1, -1, -1, 0);
    xfer(32'h1000_0100, 4, 1, 0, 2'b00, 4'hF, 0, 0, -1, -1, -1, 0);
    xfer(32'h1000_0108, 4, 1, 0, 2'b01, 4'hF, 0, 0, -1, -1, -1, 0);
    xfer(32'h1000_011C, 8, 1, 0, 2'b10, 4'hF, 0, 0, -1, -1, -1, 0);
    xfer(32'h1000_0134, 16, 1, 0, 2'b11, 4'hF, 0, 0, -1, -1, -1, 0);

    xfer(32'h1000_0100, 4, 1, 0, 2'b00, 4'hF, 0, 0, 1, -1, -1, 0);
    xfer(32'h1000_0100, 4, 1, 0, 2'b00, 4'hF, 0, 0, -1, 2, -1, 0);

    xfer(32'h1000_2000, 1, 0, 0, 2'b00, 4'hF, 0, 0, -1, -1, -1, 0);
    xfer(32'h1000_2000, 1, 0, 1, 2'b00, 4'hF, 1, 32'hCAFE_F00D, -1, -1, -1, 0);
    xfer(32'h1000_0000, 1, 0, 0, 2'b00, 4'hF, 0, 0, -1, -1, -1, 0);
    xfer(32'h1000_1FF8, 4, 1, 0, 2'b00, 4'hF, 0, 0, -1, -1, -1, 0);

    xfer(32'h1000_0200, 4, 1, 0, 2'b00, 4'hF, 0, 0, -1, -1, 1, 1);
    xfer(32'h1000_0300, 4, 1, 1, 2'b00, 4'hF, 0, 0, -1, -1, 1, 2);
    xfer(32'h1000_0300, 4, 1, 0, 2'b00, 4'hF, 0, 0, -1, -1, -1, 0);

    for (int t = 0; t < 80; t++) begin
      rb = 1'($urandom_range(0, 1));
      rn = rb ? $urandom_range(1, 8) : 1;
      ra = 32'h1000_0000 + 4 * $urandom_range(0, 2100);
      st = -1;
      mm = -1;
      if (rb && rn > 2 && $urandom_range(0, 3) == 0) st = $urandom_range(0, rn - 2);
      else if (rb && rn > 2 && $urandom_range(0, 3) == 0) mm = $urandom_range(1, rn - 1);
      xfer(ra, rn, rb, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
           4'($urandom_range(0, 15)), 0, 0, st, mm, -1, 0);
    end

    repeat (4) @(posedge clk_i);
    check("queue_drained", 32'(expq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
